// File: rtl/ifetch_buffer.sv
// Instruction-fetch requester: drives the imem word address from the fetch PC and
// buffers returned {pc, instr} pairs in a first-word-fall-through queue for decode.
module ifetch_buffer #(
    parameter int unsigned N_ADDR = 6,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PC_W   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [N_ADDR-1:0]        imem_addr,
    input  logic [31:0]              imem_q,
    input  logic                     redirect_en,
    input  logic [PC_W-1:0]          redirect_pc,
    input  logic                     deq,
    output logic                     valid,
    output logic [31:0]              instr,
    output logic [PC_W-1:0]          instr_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  r_fetch_pc;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_instr_q [DEPTH];
    logic [PC_W-1:0]  r_pc_q    [DEPTH];

    logic w_valid;
    logic w_full;
    logic w_deq_ok;
    logic w_enq;

    assign w_valid  = (r_count != '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_deq_ok = deq & w_valid;
    assign w_enq    = ~redirect_en & (~w_full | w_deq_ok);

    assign imem_addr = r_fetch_pc[N_ADDR+1:2];
    assign valid     = w_valid;
    assign full      = w_full;
    assign count     = r_count;
    // Empty queue presents zeros rather than stale storage.
    assign instr     = w_valid ? r_instr_q[r_rd_ptr] : 32'd0;
    assign instr_pc  = w_valid ? r_pc_q[r_rd_ptr]    : '0;

    // Fetch PC, pointers and occupancy; redirect overrides enqueue and dequeue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect_en) begin
            r_fetch_pc <= redirect_pc & ~PC_W'(3);
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_enq) begin
                r_fetch_pc <= r_fetch_pc + PC_W'(4);
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq_ok);
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_instr_q[i] <= '0;
                r_pc_q[i]    <= '0;
            end
        end else if (w_enq) begin
            r_instr_q[r_wr_ptr] <= imem_q;
            r_pc_q[r_wr_ptr]    <= r_fetch_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Randomized scoreboard bench for ifetch_buffer against a queue-based reference model.
module tb_ifetch_buffer;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [63:0] pc;
        logic [2:0]  count;
        logic        full;
        logic [5:0]  addr;
    } exp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk;
    logic        reset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        deq;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic [2:0]  count;
    logic        full;

    logic [31:0] rom [64];
    assign imem_q = rom[imem_addr];

    ifetch_buffer #(.N_ADDR(6), .DEPTH(DEPTH), .PC_W(64)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .deq(deq),
        .valid(valid), .instr(instr), .instr_pc(instr_pc), .count(count), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_chk  = 0;
    int     n_fail = 0;
    exp_t   sb [$];
    entry_t mq [$];
    logic [63:0] m_pc;
    logic        m_rst;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Drive one cycle of inputs and push the model's state after the coming edge.
    task automatic step(input logic rd_en, input logic [63:0] rpc, input logic dq);
        exp_t e;
        logic deq_ok;
        logic enq;
        redirect_en = rd_en;
        redirect_pc = rpc;
        deq         = dq;
        if (m_rst) begin
            mq.delete();
            m_pc = 64'd0;
        end else if (rd_en) begin
            mq.delete();
            m_pc = {rpc[63:2], 2'b00};
        end else begin
            deq_ok = dq && (mq.size() > 0);
            enq    = (mq.size() < DEPTH) || deq_ok;
            if (deq_ok) void'(mq.pop_front());
            if (enq) begin
                mq.push_back({m_pc, rom[(m_pc / 4) % 64]});
                m_pc = m_pc + 64'd4;
            end
        end
        e.valid = (mq.size() > 0);
        e.instr = e.valid ? mq[0].instr : 32'd0;
        e.pc    = e.valid ? mq[0].pc : 64'd0;
        e.count = 3'(mq.size());
        e.full  = (mq.size() == DEPTH);
        e.addr  = 6'((m_pc / 4) % 64);
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares DUT outputs just after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("valid",     64'(valid),     64'(e.valid));
                chk("count",     64'(count),     64'(e.count));
                chk("full",      64'(full),      64'(e.full));
                chk("imem_addr", 64'(imem_addr), 64'(e.addr));
                chk("instr",     64'(instr),     64'(e.instr));
                chk("instr_pc",  instr_pc,       e.pc);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"},     64'(valid),     64'd0);
        chk({tag, "_full"},      64'(full),      64'd0);
        chk({tag, "_count"},     64'(count),     64'd0);
        chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_instr"},     64'(instr),     64'd0);
        chk({tag, "_instr_pc"},  instr_pc,       64'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0]  = 32'hf8000001;
        rom[1]  = 32'hf8008002;
        rom[2]  = 32'hf8000203;
        rom[3]  = 32'h8b050083;
        rom[4]  = 32'hf8018003;
        rom[37] = 32'hb4ffff82;
        rom[47] = 32'h0;
        rom[48] = 32'h0;
        rom[49] = 32'h0;
        rom[63] = 32'h12345677;

        reset = 1'b0; redirect_en = 1'b0; redirect_pc = 64'd0; deq = 1'b0;
        m_rst = 1'b0; m_pc = 64'd0;
        #1;
        chk_zero("por");
        @(negedge clk);
        reset = 1'b1;

        // Fill to full, then one dequeue while full.
        repeat (5) step(1'b0, 64'd0, 1'b0);
        step(1'b0, 64'd0, 1'b1);
        step(1'b0, 64'd0, 1'b0);
        // Redirect with low bits set while holding entries, then stream.
        step(1'b1, 64'h97, 1'b1);
        repeat (4) step(1'b0, 64'd0, 1'b1);
        // Redirect near top of imem to exercise address wrap.
        step(1'b1, 64'hFC, 1'b1);
        repeat (4) step(1'b0, 64'd0, 1'b1);
        // Redirect into the zero-filled region; redirect held for several cycles.
        step(1'b1, 64'hBC, 1'b0);
        step(1'b1, 64'hBC, 1'b1);
        step(1'b1, 64'hBD, 1'b1);
        repeat (5) step(1'b0, 64'd0, 1'b1);

        // Random phase.
        for (int c = 0; c < 400; c++) begin
            logic        r;
            logic [63:0] t;
            r = ($urandom_range(0, 15) == 0);
            t = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) t = 64'($urandom_range(0, 1023));
            step(r, t, 1'($urandom_range(0, 1)));
        end

        // Fill, then assert reset between edges and check outputs clear before the next edge.
        repeat (5) step(1'b0, 64'd0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        m_rst = 1'b1;
        step(1'b0, 64'd0, 1'b1);
        reset = 1'b1;
        m_rst = 1'b0;
        repeat (6) step(1'b0, 64'd0, 1'($urandom_range(0, 1)));

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
